// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 serial receiver on a 16x oversampling clock with majority-vote bit sampling,
// a one-entry valid/ready holding register, and framing-error / overrun pulses.
module uart_rx_deser #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] S0 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] S1 = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] S2 = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [1:0]           sync;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 smp0, smp1, armed;
    logic                 rxs, maj, decide, wrap;

    assign rxs    = sync[1];
    assign maj    = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
    assign decide = cnt == S2;
    assign wrap   = cnt == LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sync      <= 2'b11;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            smp0      <= 1'b1;
            smp1      <= 1'b1;
            armed     <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync      <= {sync[0], rxd};
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (cnt == S0) smp0 <= rxs;
            if (cnt == S1) smp1 <= rxs;
            case (state)
                IDLE: begin
                    // armed only after rxs seen high, so a held-low line cannot retrigger
                    if (armed && !rxs) begin
                        state <= START;
                        cnt   <= CW'(1);
                        armed <= 1'b0;
                    end else if (rxs) begin
                        armed <= 1'b1;
                    end
                end
                START: begin
                    if (decide && maj) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (wrap) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    cnt <= wrap ? '0 : cnt + CW'(1);
                    if (decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
                    if (wrap) begin
                        if (bit_idx == LAST_BIT) state <= STOP;
                        else bit_idx <= bit_idx + BW'(1);
                    end
                end
                STOP: begin
                    // leave at the stop-bit centre to resync early on back-to-back frames
                    if (decide) begin
                        state <= IDLE;
                        cnt   <= '0;
                        if (!maj) begin
                            frame_err <= 1'b1;
                        end else if (!rx_valid || rx_ready) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: directed scenario tasks for uart_rx_deser with hand-computed expectations.
module tb_uart_rx_deser;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int c0 = 0;
    int nvalid, nferr, novr, first_valid;

    uart_rx_deser #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) begin
            nvalid++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (frame_err) nferr++;
        if (overrun) novr++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        nvalid = 0;
        nferr = 0;
        novr = 0;
        first_valid = -1;
    endtask

    // called just after a rising edge; the start bit begins immediately
    task automatic send_frame(input logic [7:0] b, input logic stop, input int gbit);
        c0 = cyc;
        for (int i = -1; i <= 8; i++) begin
            for (int k = 0; k < 16; k++) begin
                logic v;
                v = (i < 0) ? 1'b0 : (i == 8) ? stop : b[i];
                rxd = (i == gbit && k == 8) ? ~v : v;
                wait_cyc(1);
            end
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        wait_cyc(3);
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h exp 00", rx_data); end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_ovr got %b exp 0", overrun); end
        rst = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_basic();
        rx_ready = 1'b1;
        clear_mon();
        send_frame(8'hA5, 1'b1, -1);
        wait_cyc(20);
        vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL basic_data got %h exp a5", rx_data); end
        vectors++; if (nvalid !== 1) begin miscompares++; $display("FAIL basic_valid_cycles got %0d exp 1", nvalid); end
        vectors++; if (first_valid - c0 !== 156) begin miscompares++; $display("FAIL basic_latency got %0d exp 156", first_valid - c0); end
        vectors++; if (nferr !== 0) begin miscompares++; $display("FAIL basic_ferr got %0d exp 0", nferr); end
        vectors++; if (novr !== 0) begin miscompares++; $display("FAIL basic_ovr got %0d exp 0", novr); end
    endtask

    task automatic test_false_start();
        clear_mon();
        rxd = 1'b0;
        wait_cyc(4);
        rxd = 1'b1;
        wait_cyc(40);
        vectors++; if (nvalid !== 0) begin miscompares++; $display("FAIL false_valid got %0d exp 0", nvalid); end
        vectors++; if (nferr !== 0) begin miscompares++; $display("FAIL false_ferr got %0d exp 0", nferr); end
        vectors++; if (novr !== 0) begin miscompares++; $display("FAIL false_ovr got %0d exp 0", novr); end
        send_frame(8'h3C, 1'b1, -1);
        wait_cyc(20);
        vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL false_next_data got %h exp 3c", rx_data); end
        vectors++; if (nvalid !== 1) begin miscompares++; $display("FAIL false_next_valid got %0d exp 1", nvalid); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(8'h81, 1'b0, -1);
        rxd = 1'b0;
        wait_cyc(40);
        rxd = 1'b1;
        wait_cyc(20);
        vectors++; if (nferr !== 1) begin miscompares++; $display("FAIL ferr_pulses got %0d exp 1", nferr); end
        vectors++; if (nvalid !== 0) begin miscompares++; $display("FAIL ferr_valid got %0d exp 0", nvalid); end
        vectors++; if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL ferr_data_kept got %h exp 3c", rx_data); end
        send_frame(8'h55, 1'b1, -1);
        wait_cyc(20);
        vectors++; if (rx_data !== 8'h55) begin miscompares++; $display("FAIL ferr_next_data got %h exp 55", rx_data); end
        vectors++; if (nferr !== 1) begin miscompares++; $display("FAIL ferr_next_pulses got %0d exp 1", nferr); end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        wait_cyc(20);
        vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid got %b exp 1", rx_valid); end
        vectors++; if (rx_data !== 8'h11) begin miscompares++; $display("FAIL ovr_data got %h exp 11", rx_data); end
        vectors++; if (novr !== 1) begin miscompares++; $display("FAIL ovr_pulses got %0d exp 1", novr); end
        vectors++; if (nferr !== 0) begin miscompares++; $display("FAIL ovr_ferr got %0d exp 0", nferr); end
        rx_ready = 1'b1;
        wait_cyc(1);
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_drain_valid got %b exp 0", rx_valid); end
        vectors++; if (rx_data !== 8'h11) begin miscompares++; $display("FAIL ovr_drain_data got %h exp 11", rx_data); end
    endtask

    task automatic test_simultaneous();
        rx_ready = 1'b0;
        send_frame(8'h33, 1'b1, -1);
        wait_cyc(10);
        clear_mon();
        fork
            send_frame(8'h7E, 1'b1, -1);
            begin
                wait_cyc(155);
                rx_ready = 1'b1;
                wait_cyc(1);
                rx_ready = 1'b0;
            end
        join
        wait_cyc(10);
        vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL simul_valid got %b exp 1", rx_valid); end
        vectors++; if (rx_data !== 8'h7E) begin miscompares++; $display("FAIL simul_data got %h exp 7e", rx_data); end
        vectors++; if (novr !== 0) begin miscompares++; $display("FAIL simul_ovr got %0d exp 0", novr); end
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_glitch_and_reset();
        send_frame(8'hF0, 1'b1, 3);
        wait_cyc(20);
        vectors++; if (rx_data !== 8'hF0) begin miscompares++; $display("FAIL glitch_data got %h exp f0", rx_data); end
        vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL glitch_valid got %b exp 1", rx_valid); end
        rxd = 1'b0;
        wait_cyc(16);
        rxd = 1'b1;
        wait_cyc(16);
        rxd = 1'b0;
        wait_cyc(7);
        rst = 1'b1;
        #2;
        vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL rst_mid_data got %h exp 00", rx_data); end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got %b exp 0", rx_valid); end
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ferr got %b exp 0", frame_err); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ovr got %b exp 0", overrun); end
        rxd = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        rx_ready = 1'b1;
        wait_cyc(30);
        clear_mon();
        send_frame(8'h0F, 1'b1, -1);
        wait_cyc(20);
        vectors++; if (rx_data !== 8'h0F) begin miscompares++; $display("FAIL rst_next_data got %h exp 0f", rx_data); end
        vectors++; if (nvalid !== 1) begin miscompares++; $display("FAIL rst_next_valid got %0d exp 1", nvalid); end
        vectors++; if (nferr !== 0) begin miscompares++; $display("FAIL rst_next_ferr got %0d exp 0", nferr); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_simultaneous();
        test_glitch_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
